// File: rtl/fracnet_mac_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fracnet_mac_pkg: shared types and constants for the FracNet MAC
// Rev 1.0
// ------------------------------------------------------------------
package fracnet_mac_pkg;

  localparam int MAX_ACC_W = 128;

  localparam logic MAC_MODE_MUL = 1'b0;
  localparam logic MAC_MODE_ACC = 1'b1;

  typedef struct packed {
    logic valid;
    logic mode;
    logic first;
    logic last;
  } sideband_t;

  // Wide bit patterns; callers keep the low w bits.
  function automatic logic [MAX_ACC_W-1:0] ACC_MAX(input int w);
    return (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
  endfunction

  function automatic logic [MAX_ACC_W-1:0] ACC_MIN(input int w);
    return ~ACC_MAX(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fracnet_mac_mul_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// fracnet_mac_mul_pipe: signed multiply with NUM_REG stages and sideband
// Rev 1.0
// ------------------------------------------------------------------
module fracnet_mac_mul_pipe
  import fracnet_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 18,
  parameter int DIN1_WIDTH = 24,
  parameter int NUM_REG    = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    en_i,
  input  sideband_t                               sb_i,
  input  logic signed [DIN0_WIDTH-1:0]            a_i,
  input  logic signed [DIN1_WIDTH-1:0]            b_i,
  output sideband_t                               sb_o,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_o
);

  localparam int P = DIN0_WIDTH + DIN1_WIDTH;

  sideband_t                    sb_q [NUM_REG];
  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REG; i++) sb_q[i] <= '0;
    end else if (en_i) begin
      sb_q[0] <= sb_i;
      for (int i = 1; i < NUM_REG; i++) sb_q[i] <= sb_q[i-1];
    end
  end

  // Operand and product registers carry no reset so they fold into the DSP A/B/M registers.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  assign sb_o = sb_q[NUM_REG-1];

  generate
    if (NUM_REG == 1) begin : g_one
      assign prod_o = P'(a_q) * P'(b_q);
    end else begin : g_multi
      logic signed [P-1:0] m_q [NUM_REG-1];
      always_ff @(posedge clk_i) begin
        if (en_i) begin
          m_q[0] <= P'(a_q) * P'(b_q);
          for (int i = 1; i < NUM_REG - 1; i++) m_q[i] <= m_q[i-1];
        end
      end
      assign prod_o = m_q[NUM_REG-2];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fracnet_mac_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// fracnet_mac_pipe: pipelined signed multiply / saturating accumulate
// Rev 1.0
// ------------------------------------------------------------------
module fracnet_mac_pipe
  import fracnet_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 18,
  parameter int DIN1_WIDTH = 24,
  parameter int NUM_STAGE  = 3,
  parameter int ACC_WIDTH  = 48
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_mode,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  dout,
  output logic                         dout_ovf
);

  localparam int P   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int AW1 = ACC_WIDTH + 1;
  localparam logic [MAX_ACC_W-1:0] MAX_FULL = ACC_MAX(ACC_WIDTH);
  localparam logic [MAX_ACC_W-1:0] MIN_FULL = ACC_MIN(ACC_WIDTH);
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = MAX_FULL[ACC_WIDTH-1:0];
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = MIN_FULL[ACC_WIDTH-1:0];

  logic                        en;
  sideband_t                   in_sb;
  sideband_t                   fin_sb;
  logic signed [P-1:0]         fin_prod;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        ovf_q, ovf_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                        dout_ovf_q, dout_ovf_d;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [AW1-1:0]       sum;
  logic signed [ACC_WIDTH-1:0] sat_sum;
  logic                        clamp_hit;
  logic                        ovf_upd;

  // Enable depends only on registered state, so in_ready never looks at in_valid.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign in_sb    = '{valid: in_valid, mode: in_mode, first: in_first, last: in_last};

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign fin_sb   = in_sb;
      assign fin_prod = P'(din0) * P'(din1);
    end else begin : g_pipe
      fracnet_mac_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .NUM_REG    (NUM_STAGE - 1)
      ) u_mul (
        .clk_i  (ap_clk),
        .rst_i  (ap_rst),
        .en_i   (en),
        .sb_i   (in_sb),
        .a_i    (din0),
        .b_i    (din1),
        .sb_o   (fin_sb),
        .prod_o (fin_prod)
      );
    end
  endgenerate

  always_comb begin
    prod_ext  = ACC_WIDTH'(fin_prod);
    base      = fin_sb.first ? '0 : acc_q;
    sum       = AW1'(base) + AW1'(prod_ext);
    clamp_hit = sum[AW1-1] != sum[AW1-2];
    if (!clamp_hit)       sat_sum = sum[ACC_WIDTH-1:0];
    else if (sum[AW1-1])  sat_sum = SAT_LO;
    else                  sat_sum = SAT_HI;
    ovf_upd   = (fin_sb.first ? 1'b0 : ovf_q) | clamp_hit;

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    dout_ovf_d  = dout_ovf_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (fin_sb.valid) begin
        if (fin_sb.mode == MAC_MODE_MUL) begin
          out_valid_d = 1'b1;
          dout_d      = prod_ext;
          dout_ovf_d  = 1'b0;
        end else begin
          acc_d = sat_sum;
          ovf_d = ovf_upd;
          if (fin_sb.last) begin
            out_valid_d = 1'b1;
            dout_d      = sat_sum;
            dout_ovf_d  = ovf_upd;
          end
        end
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_ovf_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_ovf_q  <= dout_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_ovf  = dout_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fracnet_mac_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fracnet_mac_pipe: directed and reference-model bench for the MAC
// Rev 1.0
// ------------------------------------------------------------------
module tb_fracnet_mac_pipe;

  logic clk;
  logic rst;
  logic in_valid, in_mode, in_first, in_last, out_ready;
  logic signed [17:0] din0;
  logic signed [23:0] din1;

  logic rdy3, ov3, of3;
  logic signed [47:0] d3;
  logic rdys, ovs, ofs;
  logic signed [41:0] ds;
  logic rdy1, ov1, of1;
  logic signed [47:0] d1;
  logic rdy8, ov8, of8;
  logic signed [47:0] d8;

  fracnet_mac_pipe #(.DIN0_WIDTH(18), .DIN1_WIDTH(24), .NUM_STAGE(3), .ACC_WIDTH(48)) dut3 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdy3), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_first(in_first), .in_last(in_last), .out_valid(ov3),
    .out_ready(out_ready), .dout(d3), .dout_ovf(of3));

  fracnet_mac_pipe #(.DIN0_WIDTH(18), .DIN1_WIDTH(24), .NUM_STAGE(3), .ACC_WIDTH(42)) dut_sat (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdys), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_first(in_first), .in_last(in_last), .out_valid(ovs),
    .out_ready(out_ready), .dout(ds), .dout_ovf(ofs));

  fracnet_mac_pipe #(.DIN0_WIDTH(18), .DIN1_WIDTH(24), .NUM_STAGE(1), .ACC_WIDTH(48)) dut1 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdy1), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_first(in_first), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .dout(d1), .dout_ovf(of1));

  fracnet_mac_pipe #(.DIN0_WIDTH(18), .DIN1_WIDTH(24), .NUM_STAGE(8), .ACC_WIDTH(48)) dut8 (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(rdy8), .din0(din0), .din1(din1),
    .in_mode(in_mode), .in_first(in_first), .in_last(in_last), .out_valid(ov8),
    .out_ready(out_ready), .dout(d8), .dout_ovf(of8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     v, m, f, l;
    longint a, b;
    bit     ev;
    longint ed;
    bit     eo;
  } vec_t;

  typedef struct {
    int     e;
    longint d;
    bit     o;
  } exp_t;

  localparam int NV = 12;
  localparam longint MAXV = 64'sd140737488355327;   // 2^47-1
  localparam longint MINV = -64'sd140737488355328;  // -2^47

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit v, bit m, bit f, bit l, longint a, longint b,
                              bit ev, longint ed, bit eo);
    vec_t r;
    r.v = v; r.m = m; r.f = f; r.l = l; r.a = a; r.b = b;
    r.ev = ev; r.ed = ed; r.eo = eo;
    return r;
  endfunction

  task automatic drive(input bit v, input bit m, input bit f, input bit l,
                       input longint a, input longint b);
    in_valid = v; in_mode = m; in_first = f; in_last = l;
    din0 = 18'(a); din1 = 24'(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_stream(input string nm, input int e, input int lat, input int sz,
                            input exp_t fr, input logic ov, input logic signed [47:0] d,
                            input logic of, output bit pop);
    pop = (sz > 0) && (fr.e + lat == e);
    chk($sformatf("%s_e%0d_valid", nm, e), ov, pop);
    if (pop && ov) begin
      chk($sformatf("%s_e%0d_dout", nm, e), d, fr.d);
      chk($sformatf("%s_e%0d_ovf", nm, e), of, fr.o);
    end
  endtask

  vec_t vt [NV];
  exp_t q1[$];
  exp_t q8[$];

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int     rcv;
    int     k;
    bit     stalled_prev;
    bit     accepted;
    longint prev_d;
    longint expd;
    longint macc;
    bit     movf;
    exp_t   fr;
    exp_t   ent;
    bit     pop;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    // Reset state
    do_reset();
    #1;
    chk("rst_out_valid", ov3, 0);
    chk("rst_dout", d3, 0);
    chk("rst_ovf", of3, 0);
    chk("rst_in_ready", rdy3, 1);

    // Mode 0 latency: result exactly two cycles after acceptance
    drive(1, 0, 0, 0, -3, 7);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("lat_t0", ov3, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_t1", ov3, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_valid", ov3, 1);
    chk("lat_dout", d3, -21);
    chk("lat_ovf", of3, 0);
    @(posedge clk); @(negedge clk);
    chk("lat_drop", ov3, 0);

    // Table-driven back-to-back stream on the 3-stage instance
    vt[0]  = mk(1, 1, 0, 1, 4, 5, 1, 20, 0);
    vt[1]  = mk(1, 1, 1, 0, 5, 2, 0, 0, 0);
    vt[2]  = mk(1, 1, 0, 0, -1, 4, 0, 0, 0);
    vt[3]  = mk(1, 0, 0, 0, 6, -7, 1, -42, 0);
    vt[4]  = mk(1, 1, 0, 0, 3, 3, 0, 0, 0);
    vt[5]  = mk(1, 1, 0, 1, 0, 9, 1, 15, 0);
    vt[6]  = mk(1, 1, 1, 1, -8, 9, 1, -72, 0);
    vt[7]  = mk(1, 0, 0, 0, -131072, -8388608, 1, 64'sd1099511627776, 0);
    vt[8]  = mk(1, 1, 1, 1, 131071, 8388607, 1, 64'sd1099503108097, 0);
    vt[9]  = mk(0, 1, 0, 1, 100, 100, 0, 0, 0);
    vt[10] = mk(1, 1, 0, 1, 1, 1, 1, 64'sd1099503108098, 0);
    vt[11] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0);

    do_reset();
    for (int i = 0; i < NV + 2; i++) begin
      if (i < NV) drive(vt[i].v, vt[i].m, vt[i].f, vt[i].l, vt[i].a, vt[i].b);
      else        drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("tbl%0d_valid", i - 2), ov3, vt[i-2].ev);
        if (vt[i-2].ev) begin
          chk($sformatf("tbl%0d_dout", i - 2), d3, vt[i-2].ed);
          chk($sformatf("tbl%0d_ovf", i - 2), of3, vt[i-2].eo);
        end
      end
    end

    // Saturation at ACC_WIDTH = 42, then a fresh single-beat group
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 4)       drive(1, 1, c == 0, c == 3, -131072, -8388608);
      else if (c == 4) drive(1, 1, 1, 1, 1, 1);
      else             drive(0, 0, 0, 0, 0, 0);
      @(posedge clk); @(negedge clk);
      if (c == 5) begin
        chk("sat_valid", ovs, 1);
        chk("sat_dout", ds, 64'sd2199023255551);
        chk("sat_ovf", ofs, 1);
        chk("nosat48_dout", d3, 64'sd4398046511104);
        chk("nosat48_ovf", of3, 0);
      end else if (c == 6) begin
        chk("sat_next_valid", ovs, 1);
        chk("sat_next_dout", ds, 1);
        chk("sat_next_ovf", ofs, 0);
      end else if (c >= 2) begin
        chk($sformatf("sat_idle%0d", c), ovs, 0);
      end
    end

    // Backpressure: 10 products, out_ready low for 5 cycles mid-stream
    do_reset();
    rcv = 0; k = 0; stalled_prev = 0; prev_d = 0;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      if (k < 10) drive(1, 0, 0, 0, k + 1, -(2 * k + 3));
      else        drive(0, 0, 0, 0, 0, 0);
      #1;
      if (stalled_prev) begin
        chk("bp_hold_valid", ov3, 1);
        chk("bp_hold_dout", d3, prev_d);
      end
      if (ov3 && !out_ready) chk("bp_in_ready_low", rdy3, 0);
      if (ov3 && out_ready) begin
        expd = longint'(rcv + 1) * longint'(-(2 * rcv + 3));
        chk($sformatf("bp_out%0d", rcv), d3, expd);
        rcv++;
      end
      stalled_prev = ov3 && !out_ready;
      prev_d = d3;
      accepted = in_valid && rdy3;
      @(posedge clk);
      if (accepted) k++;
      @(negedge clk);
    end
    chk("bp_count", rcv, 10);
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk);
    chk("bp_no_extra", ov3, 0);

    // Asynchronous reset mid-group and while a result is held
    do_reset();
    drive(1, 0, 0, 0, 9, 9);
    @(posedge clk); @(negedge clk);
    drive(1, 1, 1, 0, 5, 5);
    @(posedge clk); @(negedge clk);
    drive(1, 1, 0, 0, 7, 7);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rg_pre_valid", ov3, 1);
    chk("rg_pre_dout", d3, 81);
    #2 rst = 1'b1;
    #1;
    chk("rg_rst_valid", ov3, 0);
    chk("rg_rst_dout", d3, 0);
    chk("rg_rst_ovf", of3, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rg_rel_in_ready", rdy3, 1);
    drive(1, 1, 1, 1, 2, 3);
    @(posedge clk); @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    chk("rg_t0", ov3, 0);
    @(posedge clk); @(negedge clk);
    chk("rg_t1", ov3, 0);
    @(posedge clk); @(negedge clk);
    chk("rg_valid", ov3, 1);
    chk("rg_dout", d3, 6);
    chk("rg_ovf", of3, 0);

    // Random mixed-mode stream against a reference model, NUM_STAGE = 1 and 8
    do_reset();
    macc = 0; movf = 0;
    for (int e = 0; e < 70; e++) begin
      bit v, m, f, l;
      logic signed [17:0] ra;
      logic signed [23:0] rb;
      longint a, b, s, base;
      bit hit;
      v = 0; m = 0; f = 0; l = 0; a = 0; b = 0;
      if (e < 55) begin
        v  = ($urandom_range(0, 3) != 0);
        m  = ($urandom_range(0, 2) != 0);
        f  = ($urandom_range(0, 3) == 0);
        l  = ($urandom_range(0, 2) == 0);
        ra = 18'($urandom);
        rb = 24'($urandom);
        a  = ra;
        b  = rb;
      end
      drive(v, m, f, l, a, b);
      @(posedge clk);
      if (v) begin
        if (!m) begin
          ent.e = e; ent.d = a * b; ent.o = 0;
          q1.push_back(ent); q8.push_back(ent);
        end else begin
          base = f ? 0 : macc;
          s = base + a * b;
          hit = 0;
          if (s > MAXV)      begin s = MAXV; hit = 1; end
          else if (s < MINV) begin s = MINV; hit = 1; end
          movf = (f ? 1'b0 : movf) | hit;
          macc = s;
          if (l) begin
            ent.e = e; ent.d = s; ent.o = movf;
            q1.push_back(ent); q8.push_back(ent);
          end
        end
      end
      @(negedge clk);
      fr = '{default: 0};
      if (q1.size() > 0) fr = q1[0];
      chk_stream("s1", e, 0, q1.size(), fr, ov1, d1, of1, pop);
      if (pop) void'(q1.pop_front());
      fr = '{default: 0};
      if (q8.size() > 0) fr = q8[0];
      chk_stream("s8", e, 7, q8.size(), fr, ov8, d8, of8, pop);
      if (pop) void'(q8.pop_front());
    end
    chk("s1_drained", q1.size(), 0);
    chk("s8_drained", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fracnet_mac_pipe.md
# fracnet_mac_pipe

Pipelined, parametrised signed multiply-accumulate unit for the FracNet compute datapath; the successor to the single-cycle combinational DSP48 multiplier wrappers. It accepts operand pairs over a valid/ready handshake and runs them through a configurable-depth multiply pipeline. Each beat is then either emitted as a plain product or folded into a saturating accumulator, which emits one result per first..last group. It sits between the weight/activation buffers and the batch-norm/threshold stage.

## Interface
- DIN0_WIDTH, 18, signed width of din0 (activation)
- DIN1_WIDTH, 24, signed width of din1 (weight/scale)
- NUM_STAGE, 3, total latency in cycles; legal range 1..8
- ACC_WIDTH, 48, accumulator/dout width; must be >= DIN0_WIDTH+DIN1_WIDTH
- ap_clk  in  1  sole clock, rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- din0  in  DIN0_WIDTH  signed operand A
- din1  in  DIN1_WIDTH  signed operand B
- in_mode  in  1  0 = multiply only, 1 = accumulate
- in_first  in  1  accumulate: beat starts a new group
- in_last  in  1  accumulate: beat closes the group
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- dout  out  ACC_WIDTH  signed product or accumulated sum
- dout_ovf  out  1  group saturated at least once; qualified by out_valid

## Operation
- Stage 1..NUM_STAGE-1: registered signed product, P = DIN0_WIDTH+DIN1_WIDTH bits, sign-extended to ACC_WIDTH. Each stage carries valid, mode, first and last alongside the data.
- Final stage, stage NUM_STAGE (the output register), acts only on a valid beat with enable high:
  - mode 0: dout = product; dout_ovf = 0; out_valid = 1; accumulator untouched.
  - mode 1: sum = (first ? 0 : acc) + product, computed at ACC_WIDTH+1 bits and clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. acc <= clamped sum. ovf <= (first ? 0 : ovf) | clamp_hit.
  - mode 1 with last = 1: out_valid = 1, dout = clamped sum, dout_ovf = updated ovf.
  - mode 1 with last = 0: out_valid = 0.
- Global enable: enable = !out_valid || out_ready. in_ready = enable, so no in_ready->in_valid combinational dependency exists.
- When enable is low the whole pipeline holds, including bubbles.
- Bubbles advance when enable is high; a bubble reaching the final stage drops out_valid once the held result is taken.
- NUM_STAGE = 1: multiply and accumulate happen in the single output register.

## Timing
- Reset (async assert, sync release):
  - out_valid = 0, dout = 0, dout_ovf = 0, acc = 0, ovf = 0, all stage valids 0.
  - in_ready = 1 in the first cycle after release.
- Latency: a beat accepted at edge t has its result visible after edge t+NUM_STAGE-1, i.e. out_valid is high in cycle t+NUM_STAGE-1 with no backpressure. Each out_ready-low cycle adds one.
- Throughput: one beat per cycle while out_ready stays high.
- first && last on the same beat: dout = product; ovf reflects only that beat (always 0).
- First mode-1 beat after reset with first = 0: accumulates onto acc = 0.
- mode-0 beats interleaved within a mode-1 group: emitted normally; group continues afterwards.
- Saturation is sticky within a group. Once clamped, later opposite-sign products add onto the clamped value; there is no rewind.
- ap_rst mid-group or mid-stall: all in-flight beats and the partial sum are discarded with no output.
- din*, in_mode, in_first and in_last are ignored when in_valid = 0.

## Structure
- Package fracnet_mac_pkg:
  - ACC_MAX and ACC_MIN functions of ACC_WIDTH.
  - sideband struct {valid, mode, first, last}.
  - mode encoding constants MAC_MODE_MUL = 0, MAC_MODE_ACC = 1.
- Sub-module fracnet_mac_mul_pipe:
  - signed multiply plus NUM_STAGE-1 register stages, with enable and sideband.
  - register placement must allow DSP48 absorption.
- Top level holds the accumulator, saturation logic, output register and handshake.

## Test plan
- Mode 0, NUM_STAGE = 3: din0 = -3, din1 = 7, out_ready = 1. Result: dout = -21, out_valid exactly 2 cycles after acceptance, dout_ovf = 0.
- Mode 1, group of four beats (5,2), (-1,4), (3,3), (0,9), first on beat 1, last on beat 4. Result: one output, dout = 15; no out_valid on beats 1-3.
- Saturation: ACC_WIDTH = 42, maximum-magnitude products (din0 = -2^17, din1 = -2^23), 4 beats. Result: dout = 2^41-1, dout_ovf = 1. The next group with first = 1 and a single beat (1,1) gives dout = 1, dout_ovf = 0.
- Backpressure: stream 10 mode-0 beats while holding out_ready low for 5 cycles mid-stream. Required: all 10 products appear in order, none lost or duplicated, dout stable while stalled, in_ready low during the stall.
- Reset mid-group: 2 mode-1 beats accepted, ap_rst pulses asynchronously, then group (2,3) with first = last = 1. Required: all outputs 0 during reset, next dout = 6 with no residue from before reset.
- Parameter sweep: NUM_STAGE = 1 and 8 with a random mixed-mode stream, compared against a reference model. Required: exact match and latency equal to NUM_STAGE-1 cycles.
